// File: rtl/kp_scan_pkg.sv
// rtl/kp_scan_pkg.sv - shared constants, FSM encoding and keypoint record for the keypoint scan controller
package kp_scan_pkg;

  localparam int COORD_W        = 10;
  localparam int KP_W           = 2 * COORD_W;

  localparam int DEF_IMG_W      = 640;
  localparam int DEF_IMG_H      = 480;
  localparam int DEF_BORDER     = 2;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } kp_t;

endpackage

// File: rtl/kp_fifo.sv
// rtl/kp_fifo.sv - synchronous first-word-fall-through keypoint queue with full/empty flags
module kp_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic [DW-1:0] m_tdata,
  input  logic          m_tready,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          pop;
  logic          push_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = m_tready & ~empty;
  assign push_ok = s_tvalid & (~full | pop);
  assign m_tdata = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + (AW+1)'(push_ok);
    rd_d = rd_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= s_tdata;
    end
  end

endmodule

// File: rtl/keypoint_scan_ctrl.sv
// rtl/keypoint_scan_ctrl.sv - raster scan FSM queueing interior detector maxima; KP_DROP_CNT_EN adds oDrop_cnt
module keypoint_scan_ctrl
  import kp_scan_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int BORDER     = DEF_BORDER,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic               iFrame_start,
  input  logic               iDet_dval,
  input  logic               iMax_en,
  output logic [COORD_W-1:0] oKp_x,
  output logic [COORD_W-1:0] oKp_y,
  output logic               oKp_valid,
  input  logic               iKp_ready,
  output logic               oBusy,
  output logic               oFrame_done,
  output logic               oOvf,
  output logic               oSeq_err
`ifdef KP_DROP_CNT_EN
  ,
  output logic [15:0]        oDrop_cnt
`endif
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] X_MIN  = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] Y_MIN  = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(IMG_W - 1 - BORDER);
  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(IMG_H - 1 - BORDER);

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               ovf_q, ovf_d;
  logic               seq_err_q, seq_err_d;

  logic interior;
  logic push;
  logic pop;
  logic drop;
  logic fifo_full;
  logic fifo_empty;
  logic arm;
  kp_t  push_kp;
  kp_t  head_kp;

  assign interior = (x_q >= X_MIN) && (x_q <= X_MAX) && (y_q >= Y_MIN) && (y_q <= Y_MAX);
  assign push     = iDet_dval & iMax_en & (state_q == ST_SCAN) & interior;
  assign pop      = oKp_valid & iKp_ready;
  // A full queue still takes the new entry when the head leaves in the same cycle.
  assign drop     = push & fifo_full & ~pop;
  assign arm      = (state_q == ST_IDLE) & iFrame_start;
  assign push_kp  = '{x: x_q, y: y_q};

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    seq_err_d = seq_err_q;
    case (state_q)
      ST_IDLE: begin
        if (iFrame_start) begin
          x_d       = '0;
          y_d       = '0;
          ovf_d     = 1'b0;
          seq_err_d = 1'b0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (iFrame_start) seq_err_d = 1'b1;
        if (iDet_dval) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = ST_DONE;
            end else begin
              y_d = y_q + COORD_W'(1);
            end
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (iFrame_start) seq_err_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ovf_q     <= ovf_d;
      seq_err_q <= seq_err_d;
    end
  end

`ifdef KP_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (arm) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign oDrop_cnt = drop_cnt_q;
`endif

  kp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (KP_W)
  ) u_fifo (
    .clk      (iclk),
    .rst      (irst),
    .s_tdata  (push_kp),
    .s_tvalid (push),
    .m_tdata  (head_kp),
    .m_tready (iKp_ready),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign oKp_x       = head_kp.x;
  assign oKp_y       = head_kp.y;
  assign oKp_valid   = ~fifo_empty;
  assign oBusy       = (state_q != ST_IDLE);
  assign oFrame_done = (state_q == ST_DONE);
  assign oOvf        = ovf_q;
  assign oSeq_err    = seq_err_q;

endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// tb/tb_keypoint_scan_ctrl.sv - self-checking bench for keypoint_scan_ctrl against a pixel-index/queue model
module tb_keypoint_scan_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int B    = 1;
  localparam int D    = 4;
  localparam int NPIX = W * H;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       iFrame_start = 1'b0;
  logic       iDet_dval = 1'b0;
  logic       iMax_en = 1'b0;
  logic       iKp_ready = 1'b0;
  logic [9:0] oKp_x, oKp_y;
  logic       oKp_valid, oBusy, oFrame_done, oOvf, oSeq_err;
`ifdef KP_DROP_CNT_EN
  logic [15:0] oDrop_cnt;
`endif

  keypoint_scan_ctrl #(
    .IMG_W(W), .IMG_H(H), .BORDER(B), .FIFO_DEPTH(D)
  ) dut (
    .iclk         (iclk),
    .irst         (irst),
    .iFrame_start (iFrame_start),
    .iDet_dval    (iDet_dval),
    .iMax_en      (iMax_en),
    .oKp_x        (oKp_x),
    .oKp_y        (oKp_y),
    .oKp_valid    (oKp_valid),
    .iKp_ready    (iKp_ready),
    .oBusy        (oBusy),
    .oFrame_done  (oFrame_done),
    .oOvf         (oOvf),
    .oSeq_err     (oSeq_err)
`ifdef KP_DROP_CNT_EN
    ,
    .oDrop_cnt    (oDrop_cnt)
`endif
  );

  always #5 iclk = ~iclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 0;
  int          fd_cnt  = 0;
  logic [19:0] got_q[$];
  bit          max_map [NPIX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position as a flat pixel index, keypoints as a bounded queue.
  bit          m_scan, m_done, m_ovf, m_seq;
  int          m_pix, m_drops;
  logic [19:0] m_q[$];

  always @(posedge iclk) begin
    bit pop, push;
    int px, py;
    if (irst) begin
      m_scan = 0; m_done = 0; m_pix = 0; m_ovf = 0; m_seq = 0; m_drops = 0;
      m_q.delete();
    end else begin
      pop  = (m_q.size() > 0) && iKp_ready;
      push = 0;
      if (m_done) begin
        m_done = 0;
        if (iFrame_start) m_seq = 1;
      end else if (m_scan) begin
        if (iFrame_start) m_seq = 1;
        if (iDet_dval) begin
          px = m_pix % W;
          py = m_pix / W;
          push = iMax_en && px >= B && px <= W-1-B && py >= B && py <= H-1-B;
          if (m_pix == NPIX-1) begin
            m_scan = 0;
            m_done = 1;
          end else begin
            m_pix++;
          end
        end
      end else if (iFrame_start) begin
        m_scan = 1; m_pix = 0; m_ovf = 0; m_seq = 0; m_drops = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < D) m_q.push_back({10'(px), 10'(py)});
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  end

  always @(negedge iclk) begin
    logic [19:0] h;
    if (chk_en) begin
      h = (m_q.size() > 0) ? m_q[0] : 20'd0;
      check("busy",       oBusy,       m_scan || m_done);
      check("frame_done", oFrame_done, m_done);
      check("kp_valid",   oKp_valid,   m_q.size() > 0);
      check("kp_x",       oKp_x,       h[19:10]);
      check("kp_y",       oKp_y,       h[9:0]);
      check("ovf",        oOvf,        m_ovf);
      check("seq_err",    oSeq_err,    m_seq);
`ifdef KP_DROP_CNT_EN
      check("drop_cnt",   oDrop_cnt,   m_drops);
`endif
    end
  end

  task automatic tick();
    if (oKp_valid === 1'b1 && iKp_ready) got_q.push_back({oKp_x, oKp_y});
    @(posedge iclk);
    @(negedge iclk);
    if (oFrame_done === 1'b1) fd_cnt++;
  endtask

  task automatic set_ready(input int mode);
    case (mode)
      0:       iKp_ready = 1'b0;
      1:       iKp_ready = 1'b1;
      default: iKp_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic start_frame();
    iFrame_start = 1'b1;
    tick();
    iFrame_start = 1'b0;
  endtask

  task automatic send_pixels(input int from, input int to, input bit gaps, input int rmode, input bit seq);
    for (int p = from; p <= to; p++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          iDet_dval = 1'b0;
          iMax_en   = 1'($urandom_range(0, 1));
          set_ready(rmode);
          tick();
        end
      end
      iDet_dval    = 1'b1;
      iMax_en      = max_map[p];
      iFrame_start = seq && ($urandom_range(0, 15) == 0);
      set_ready(rmode);
      tick();
      iFrame_start = 1'b0;
    end
    iDet_dval = 1'b0;
    iMax_en   = 1'b0;
  endtask

  // Detector activity outside SCAN must be ignored, so idle gaps carry noise.
  task automatic idle(input int n, input int rmode);
    repeat (n) begin
      iDet_dval = 1'($urandom_range(0, 1));
      iMax_en   = 1'($urandom_range(0, 1));
      set_ready(rmode);
      tick();
    end
    iDet_dval = 1'b0;
    iMax_en   = 1'b0;
  endtask

  task automatic clear_map();
    for (int i = 0; i < NPIX; i++) max_map[i] = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    irst   = 1'b0;
    chk_en = 1;

    // basic detection at (3,2)
    clear_map();
    max_map[2*W+3] = 1'b1;
    got_q.delete(); fd_cnt = 0;
    iKp_ready = 1'b1;
    start_frame();
    send_pixels(0, NPIX-1, 0, 1, 0);
    check("s1_done_after_last", oFrame_done, 1'b1);
    idle(4, 1);
    check("s1_kp_count", got_q.size(), 1);
    check("s1_kp_xy", (got_q.size() > 0) ? got_q[0] : 20'hFFFFF, {10'd3, 10'd2});
    check("s1_done_count", fd_cnt, 1);

    // border masking
    clear_map();
    max_map[0] = 1'b1; max_map[3*W+7] = 1'b1; max_map[5*W+4] = 1'b1;
    got_q.delete();
    start_frame();
    send_pixels(0, NPIX-1, 1, 1, 0);
    idle(4, 1);
    check("s2_border_none", got_q.size(), 0);

    // backpressure overflow
    clear_map();
    for (int i = 1; i <= 5; i++) max_map[W+i] = 1'b1;
    got_q.delete();
    iKp_ready = 1'b0;
    start_frame();
    send_pixels(0, NPIX-1, 0, 0, 0);
    check("s3_ovf", oOvf, 1'b1);
    check("s3_valid", oKp_valid, 1'b1);
`ifdef KP_DROP_CNT_EN
    check("s3_drop_cnt", oDrop_cnt, 16'd1);
`endif
    idle(6, 1);
    check("s3_drained", got_q.size(), 4);
    check("s3_first", (got_q.size() > 0) ? got_q[0] : 20'hFFFFF, {10'd1, 10'd1});
    check("s3_last",  (got_q.size() > 3) ? got_q[3] : 20'hFFFFF, {10'd4, 10'd1});

    // full with simultaneous push and pop
    got_q.delete();
    iKp_ready = 1'b0;
    start_frame();
    check("s4_ovf_cleared", oOvf, 1'b0);
    send_pixels(0, W+4, 0, 0, 0);
    send_pixels(W+5, W+5, 0, 1, 0);
    send_pixels(W+6, NPIX-1, 0, 0, 0);
    check("s4_no_ovf", oOvf, 1'b0);
    idle(6, 1);
    check("s4_total", got_q.size(), 5);
    check("s4_tail", (got_q.size() > 4) ? got_q[4] : 20'hFFFFF, {10'd5, 10'd1});

    // frame start while scanning
    clear_map();
    max_map[2*W+3] = 1'b1;
    got_q.delete(); fd_cnt = 0;
    start_frame();
    send_pixels(0, 19, 0, 1, 0);
    iFrame_start = 1'b1;
    tick();
    iFrame_start = 1'b0;
    check("s5_seq_err", oSeq_err, 1'b1);
    check("s5_busy", oBusy, 1'b1);
    send_pixels(20, NPIX-1, 0, 1, 0);
    check("s5_done_on_orig_last", oFrame_done, 1'b1);
    idle(3, 1);
    check("s5_done_count", fd_cnt, 1);

    // reset mid-frame
    clear_map();
    max_map[W+1] = 1'b1; max_map[W+2] = 1'b1;
    got_q.delete(); fd_cnt = 0;
    iKp_ready = 1'b0;
    start_frame();
    send_pixels(0, 19, 0, 0, 0);
    irst = 1'b1;
    tick();
    irst = 1'b0;
    check("s6_valid",   oKp_valid,   1'b0);
    check("s6_busy",    oBusy,       1'b0);
    check("s6_done",    oFrame_done, 1'b0);
    check("s6_ovf",     oOvf,        1'b0);
    check("s6_seq_err", oSeq_err,    1'b0);
    check("s6_kp_xy",   {oKp_x, oKp_y}, 20'd0);
    send_pixels(20, NPIX-1, 0, 0, 0);
    idle(4, 1);
    check("s6_no_done", fd_cnt, 0);
    check("s6_no_kp", got_q.size(), 0);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NPIX; i++) max_map[i] = ($urandom_range(0, 3) == 0);
      set_ready(2);
      start_frame();
      send_pixels(0, NPIX-1, 1, 2, 1);
      idle($urandom_range(1, 5), 2);
    end
    idle(12, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
